reaction_display: RTL
=====================

// Module: reaction_display
// PURPOSE
//  Downstream of the reaction-test FSM. Consumes its state code and 14-bit
//  response time (ms). Converts the time to 4-digit BCD with a sequential
//  double-dabble (one shift per clock) and drives a multiplexed 4-digit
//  common-anode 7-segment display. Segment content depends on the FSM state.
// PARAMETERS
//  SCAN_DIV  50000  clock cycles each digit stays enabled (>=2; bench uses 4)
// PORTS
//  clk              in   1   system clock, rising edge
//  rst              in   1   asynchronous, active-high reset
//  i_state          in   3   FSM state: 0 IDLE, 1 WAIT, 2 TEST, 3 DONE, 4 FAIL
//  i_response_time  in   14  response time in ms, unsigned
//  o_bcd            out  16  last completed conversion {thousands,hundreds,tens,units}
//  o_bcd_valid      out  1   1-cycle pulse when o_bcd updates
//  o_busy           out  1   conversion in progress
//  o_seg            out  7   {g,f,e,d,c,b,a}, active-low (0 = lit)
//  o_an             out  4   digit enables, active-low one-hot; bit0 = units
// BEHAVIOUR
//  Reset: o_bcd=0, o_bcd_valid=0, o_busy=0, o_seg=7'h7F, o_an=4'hF,
//   scan counter=0, digit index=0, internal prev-state=IDLE.
//  Conversion trigger:
//   - Capture cycle C: DONE entry (i_state==3, registered prev!=3), or
//     i_state==2 and not busy.
//   - DONE entry aborts any conversion in flight and restarts.
//   - Captured value saturates to 9999 if >9999.
//  Conversion timing:
//   - C+1..C+14: one add-3/shift step per cycle, o_busy=1.
//   - C+15: o_bcd loaded, o_bcd_valid=1 for one cycle, o_busy=0.
//   - In TEST, conversions run back-to-back (next capture at C+15).
//   - Leaving TEST for a state other than DONE aborts: no valid pulse, o_bcd kept.
//  Scanner:
//   - Counter runs 0..SCAN_DIV-1. At terminal count the digit index advances
//     0->1->2->3->0.
//   - o_an/o_seg are registered from the index and content: 1-cycle latency.
//     The first cycle after reset release gives o_an=4'b1110.
//  Digit content by state (digit3..digit0):
//   IDLE "----" ('-'=7'h3F); WAIT blank (7'h7F);
//   TEST and DONE: o_bcd with leading zeros blanked; units digit always shown;
//   FAIL "FAIL" (F=7'h0E, A=7'h08, I=7'h4F, L=7'h47);
//   codes 5-7: blank.
//  Digit codes: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
//  Content changes take effect on the next scan register update, not at a
//   digit boundary.
//  Reset mid-conversion: abort immediately, no valid pulse, o_bcd=0.
// TESTING
//  1 Reset, SCAN_DIV=4 -> o_seg=7'h7F, o_an=4'hF during reset; after release
//    o_an 1110,1101,1011,0111, each held 4 cycles, then repeats.
//  2 DONE entry, time=357 -> o_bcd_valid at C+15, o_bcd=16'h0357;
//    digits 3..0 = 7F,30,12,78.
//  3 DONE entry, time=12000 -> o_bcd=16'h9999, all digits 7'h10.
//  4 i_state=4 -> digits 3..0 = 0E,08,4F,47; o_bcd_valid never pulses.
//  5 TEST time=100, DONE entry at C+7 with time=42 -> no pulse for 100;
//    one pulse 15 cycles after DONE entry, o_bcd=16'h0042.
//  6 rst asserted at C+5 of a conversion -> o_busy=0, o_bcd=0; no pulse until
//    a new trigger.

Source files
------------

// File: rtl/reaction_display.sv
`default_nettype none
// ============================================================================
// Module      : reaction_display
// Description : Converts the reaction time to BCD (sequential double-dabble)
//               and drives a multiplexed 4-digit common-anode 7-seg display.
// Revision    : 1.0 - initial release
// ============================================================================
module reaction_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  i_state,
    input  logic [13:0] i_response_time,
    output logic [15:0] o_bcd,
    output logic        o_bcd_valid,
    output logic        o_busy,
    output logic [6:0]  o_seg,
    output logic [3:0]  o_an
);

    localparam logic [2:0]  c_ST_IDLE = 3'd0;
    localparam logic [2:0]  c_ST_WAIT = 3'd1;
    localparam logic [2:0]  c_ST_TEST = 3'd2;
    localparam logic [2:0]  c_ST_DONE = 3'd3;
    localparam logic [2:0]  c_ST_FAIL = 3'd4;
    localparam logic [13:0] c_MAX_VAL = 14'd9999;
    localparam logic [3:0]  c_LAST_STEP = 4'd13;
    localparam int          c_CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(SCAN_DIV - 1);

    localparam logic [6:0]  c_SEG_BLANK = 7'h7F;
    localparam logic [6:0]  c_SEG_DASH  = 7'h3F;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } conv_state_t;

    conv_state_t         r_conv_state;
    logic [2:0]          r_prev_state;
    logic [13:0]         r_shift;
    logic [15:0]         r_acc;
    logic [3:0]          r_step;
    logic [c_CNT_W-1:0]  r_scan_cnt;
    logic [1:0]          r_digit_idx;

    logic                w_done_entry;
    logic                w_capture;
    logic                w_keep;
    logic [13:0]         w_sat_val;
    logic [15:0]         w_acc_adj;
    logic [15:0]         w_acc_next;
    logic [3:0]          w_digit;
    logic                w_blank;
    logic [6:0]          w_seg;

    function automatic logic [6:0] f_seg7(input logic [3:0] d);
        case (d)
            4'd0:    f_seg7 = 7'h40;
            4'd1:    f_seg7 = 7'h79;
            4'd2:    f_seg7 = 7'h24;
            4'd3:    f_seg7 = 7'h30;
            4'd4:    f_seg7 = 7'h19;
            4'd5:    f_seg7 = 7'h12;
            4'd6:    f_seg7 = 7'h02;
            4'd7:    f_seg7 = 7'h78;
            4'd8:    f_seg7 = 7'h00;
            4'd9:    f_seg7 = 7'h10;
            default: f_seg7 = 7'h7F;
        endcase
    endfunction

    // A DONE entry always wins, restarting any conversion already running.
    assign w_done_entry = (i_state == c_ST_DONE) && (r_prev_state != c_ST_DONE);
    assign w_capture    = w_done_entry || ((i_state == c_ST_TEST) && (r_conv_state == S_IDLE));
    assign w_keep       = (i_state == c_ST_TEST) || (i_state == c_ST_DONE);
    assign w_sat_val    = (i_response_time > c_MAX_VAL) ? c_MAX_VAL : i_response_time;
    assign o_busy       = (r_conv_state == S_CONV);

    always_comb begin
        w_acc_adj = r_acc;
        for (int i = 0; i < 4; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
        w_acc_next = {w_acc_adj[14:0], r_shift[13]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conv_state <= S_IDLE;
            r_prev_state <= c_ST_IDLE;
            r_shift      <= '0;
            r_acc        <= '0;
            r_step       <= '0;
            o_bcd        <= '0;
            o_bcd_valid  <= 1'b0;
        end else begin
            r_prev_state <= i_state;
            o_bcd_valid  <= 1'b0;
            if (w_capture) begin
                r_conv_state <= S_CONV;
                r_shift      <= w_sat_val;
                r_acc        <= '0;
                r_step       <= '0;
            end else if (r_conv_state == S_CONV) begin
                if (!w_keep) begin
                    r_conv_state <= S_IDLE;
                end else begin
                    r_acc   <= w_acc_next;
                    r_shift <= {r_shift[12:0], 1'b0};
                    r_step  <= r_step + 4'd1;
                    if (r_step == c_LAST_STEP) begin
                        r_conv_state <= S_IDLE;
                        o_bcd        <= w_acc_next;
                        o_bcd_valid  <= 1'b1;
                    end
                end
            end
        end
    end

    // Leading zeros blank from the left; the units digit is always shown.
    always_comb begin
        w_digit = o_bcd[4*r_digit_idx +: 4];
        case (r_digit_idx)
            2'd3:    w_blank = (o_bcd[15:12] == 4'd0);
            2'd2:    w_blank = (o_bcd[15:8] == 8'd0);
            2'd1:    w_blank = (o_bcd[15:4] == 12'd0);
            default: w_blank = 1'b0;
        endcase

        case (i_state)
            c_ST_IDLE: w_seg = c_SEG_DASH;
            c_ST_WAIT: w_seg = c_SEG_BLANK;
            c_ST_TEST,
            c_ST_DONE: w_seg = w_blank ? c_SEG_BLANK : f_seg7(w_digit);
            c_ST_FAIL: begin
                case (r_digit_idx)
                    2'd3:    w_seg = 7'h0E;
                    2'd2:    w_seg = 7'h08;
                    2'd1:    w_seg = 7'h4F;
                    default: w_seg = 7'h47;
                endcase
            end
            default:   w_seg = c_SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= '0;
            o_an        <= 4'hF;
            o_seg       <= c_SEG_BLANK;
        end else begin
            o_an  <= ~(4'b0001 << r_digit_idx);
            o_seg <= w_seg;
            if (r_scan_cnt == c_CNT_MAX) begin
                r_scan_cnt  <= '0;
                r_digit_idx <= r_digit_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
